// File: rtl/video_adj_pkg.sv
// Shared constants and saturating helpers for the brightness/contrast pipeline.
// The *_DEF values describe the default configuration; modules rescale them to their own widths.
package video_adj_pkg;

  localparam int PIPE_DEPTH = 3;

  localparam int DEF_DW   = 8;
  localparam int DEF_GW   = 8;
  localparam int DEF_FRAC = 6;
  localparam int DEF_BW   = 8;

  localparam int UNITY_GAIN = 2 ** DEF_FRAC;
  localparam int MID_GREY   = 2 ** (DEF_DW - 1);

  function automatic int sat_add(input int v, input int delta, input int lo, input int hi);
    int s;
    s = v + delta;
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

  // One key-driven step; simultaneous up and down cancel out.
  function automatic int step_setting(input int v, input int step, input logic up,
                                      input logic dn, input int lo, input int hi);
    if (up && !dn) return sat_add(v, step, lo, hi);
    if (dn && !up) return sat_add(v, -step, lo, hi);
    return v;
  endfunction

endpackage

// File: rtl/adj_channel.sv
// One colour channel of the adjust pipeline: centre on mid-grey, apply gain,
// re-centre, add brightness, clamp. Three register stages, no stall.
module adj_channel
  import video_adj_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int GW   = DEF_GW,
  parameter int FRAC = DEF_FRAC,
  parameter int BW   = DEF_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x,
  input  logic          de,
  input  logic          byp,
  input  logic [GW-1:0] gain,
  input  logic [BW-1:0] bright,
  output logic [DW-1:0] y
);

  localparam int PW  = DW + GW + 2;
  localparam int SW  = PW + 1;
  localparam int MID = (MID_GREY >> (DEF_DW - 1)) << (DW - 1);

  localparam logic signed [DW:0]   MID_D   = (DW + 1)'(MID);
  localparam logic signed [SW-1:0] MID_S   = SW'(MID);
  localparam logic signed [SW-1:0] PIX_MAX = SW'((2 ** DW) - 1);

  logic signed [DW:0]    d1;
  logic [DW-1:0]         x1;
  logic                  de1, byp1;
  logic [GW-1:0]         g1;
  logic signed [BW-1:0]  b1;

  logic signed [PW-1:0]  p2;
  logic [DW-1:0]         x2;
  logic                  de2, byp2;
  logic signed [BW-1:0]  b2;

  logic signed [PW-1:0]  d_ext, g_ext;
  logic signed [SW-1:0]  sum3;
  logic [DW-1:0]         y_adj;

  assign d_ext = PW'(d1);
  assign g_ext = PW'({1'b0, g1});

  always_comb begin
    sum3 = SW'(p2 >>> FRAC) + SW'(b2) + MID_S;
    if (sum3[SW-1])          y_adj = '0;
    else if (sum3 > PIX_MAX) y_adj = '1;
    else                     y_adj = sum3[DW-1:0];
  end

  // Raw pixel and bypass flag ride alongside so bypass is bit-exact per pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1   <= '0;
      x1   <= '0;
      de1  <= 1'b0;
      byp1 <= 1'b0;
      g1   <= '0;
      b1   <= '0;
      p2   <= '0;
      x2   <= '0;
      de2  <= 1'b0;
      byp2 <= 1'b0;
      b2   <= '0;
      y    <= '0;
    end else begin
      d1   <= $signed({1'b0, x}) - MID_D;
      x1   <= x;
      de1  <= de;
      byp1 <= byp;
      g1   <= gain;
      b1   <= bright;
      p2   <= d_ext * g_ext;
      x2   <= x1;
      de2  <= de1;
      byp2 <= byp1;
      b2   <= b1;
      y    <= de2 ? (byp2 ? x2 : y_adj) : '0;
    end
  end

endmodule

// File: rtl/video_adjust_pipe.sv
// Brightness/contrast stage between frame-buffer read and HDMI encoder.
// Key pulses edit shadow settings; they become active only at Vsync rise.
module video_adjust_pipe
  import video_adj_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NCH   = 3,
  parameter int GW    = DEF_GW,
  parameter int FRAC  = DEF_FRAC,
  parameter int BW    = DEF_BW,
  parameter int CSTEP = 6,
  parameter int BSTEP = 6
) (
  input  logic              Pclk,
  input  logic              Rst,
  input  logic              Vsync,
  input  logic              Hsync,
  input  logic              De,
  input  logic [NCH*DW-1:0] RGB,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              sel,
  input  logic              bypass,
  output logic              Vsync_o,
  output logic              Hsync_o,
  output logic              De_o,
  output logic [NCH*DW-1:0] RGB_o,
  output logic [GW-1:0]     cur_gain,
  output logic [BW-1:0]     cur_bright
);

  localparam int UNITY      = (UNITY_GAIN >> DEF_FRAC) << FRAC;
  localparam int GAIN_MAX   = (2 ** GW) - 1;
  localparam int BRIGHT_MIN = -(2 ** (BW - 1));
  localparam int BRIGHT_MAX = (2 ** (BW - 1)) - 1;

  logic [GW-1:0]        shadow_gain, active_gain;
  logic signed [BW-1:0] shadow_bright, active_bright;
  logic                 vsync_q;
  logic                 frame_start;

  logic [PIPE_DEPTH-1:0] vs_d, hs_d, de_d;

  assign frame_start = Vsync & ~vsync_q;

  // Commit reads the pre-update shadow, so a pulse on the edge cycle waits a frame.
  always_ff @(posedge Pclk or posedge Rst) begin
    if (Rst) begin
      shadow_gain   <= GW'(UNITY);
      active_gain   <= GW'(UNITY);
      shadow_bright <= '0;
      active_bright <= '0;
      vsync_q       <= 1'b0;
    end else begin
      vsync_q <= Vsync;
      if (!sel)
        shadow_gain <= GW'(step_setting(int'(shadow_gain), CSTEP, inc_pulse, dec_pulse,
                                        0, GAIN_MAX));
      else
        shadow_bright <= BW'(step_setting(int'(shadow_bright), BSTEP, inc_pulse, dec_pulse,
                                          BRIGHT_MIN, BRIGHT_MAX));
      if (frame_start) begin
        active_gain   <= shadow_gain;
        active_bright <= shadow_bright;
      end
    end
  end

  always_ff @(posedge Pclk or posedge Rst) begin
    if (Rst) begin
      vs_d <= '0;
      hs_d <= '0;
      de_d <= '0;
    end else begin
      vs_d <= {vs_d[PIPE_DEPTH-2:0], Vsync};
      hs_d <= {hs_d[PIPE_DEPTH-2:0], Hsync};
      de_d <= {de_d[PIPE_DEPTH-2:0], De};
    end
  end

  assign Vsync_o    = vs_d[PIPE_DEPTH-1];
  assign Hsync_o    = hs_d[PIPE_DEPTH-1];
  assign De_o       = de_d[PIPE_DEPTH-1];
  assign cur_gain   = active_gain;
  assign cur_bright = active_bright;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    adj_channel #(
      .DW   (DW),
      .GW   (GW),
      .FRAC (FRAC),
      .BW   (BW)
    ) u_ch (
      .clk    (Pclk),
      .rst    (Rst),
      .x      (RGB[i*DW +: DW]),
      .de     (De),
      .byp    (bypass),
      .gain   (active_gain),
      .bright (active_bright),
      .y      (RGB_o[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_video_adjust_pipe.sv
// Directed bench for video_adjust_pipe: a pixel-level reference model compared
// every cycle, plus hand-computed literal expectations.
module tb_video_adjust_pipe;

  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int W   = NCH * DW;

  logic         Pclk = 1'b0;
  logic         Rst;
  logic         Vsync, Hsync, De;
  logic [W-1:0] RGB;
  logic         inc_pulse, dec_pulse, sel, bypass;
  logic         Vsync_o, Hsync_o, De_o;
  logic [W-1:0] RGB_o;
  logic [7:0]   cur_gain;
  logic [7:0]   cur_bright;

  int   n_checks = 0;
  int   n_errors = 0;
  logic check_en = 1'b0;
  logic done     = 1'b0;

  always #5 Pclk = ~Pclk;

  video_adjust_pipe dut (
    .Pclk       (Pclk),
    .Rst        (Rst),
    .Vsync      (Vsync),
    .Hsync      (Hsync),
    .De         (De),
    .RGB        (RGB),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .sel        (sel),
    .bypass     (bypass),
    .Vsync_o    (Vsync_o),
    .Hsync_o    (Hsync_o),
    .De_o       (De_o),
    .RGB_o      (RGB_o),
    .cur_gain   (cur_gain),
    .cur_bright (cur_bright)
  );

  // ---------------- reference model ----------------
  int           m_shadow_gain, m_shadow_bright, m_gain, m_bright;
  logic         m_prev_vs;
  logic [W+2:0] exp_q[$];

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int adj_value(input int x, input int g, input int b);
    int p, q;
    p = (x - 128) * g;
    q = p / 64;
    if (p < 0 && (p % 64) != 0) q = q - 1;
    return clampi(q + 128 + b, 0, 255);
  endfunction

  function automatic logic [W-1:0] model_pixel(input logic [W-1:0] rgb, input logic de,
                                               input logic byp, input int g, input int b);
    logic [W-1:0] r;
    r = '0;
    if (de)
      for (int c = 0; c < NCH; c++)
        r[c*8 +: 8] = byp ? rgb[c*8 +: 8] : 8'(adj_value(int'(rgb[c*8 +: 8]), g, b));
    return r;
  endfunction

  always @(posedge Pclk or posedge Rst) begin
    if (Rst) begin
      m_shadow_gain   = 64;
      m_shadow_bright = 0;
      m_gain          = 64;
      m_bright        = 0;
      m_prev_vs       = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back('0);
    end else begin
      exp_q.push_back({Vsync, Hsync, De, model_pixel(RGB, De, bypass, m_gain, m_bright)});
      void'(exp_q.pop_front());
      if (Vsync && !m_prev_vs) begin
        m_gain   = m_shadow_gain;
        m_bright = m_shadow_bright;
      end
      m_prev_vs = Vsync;
      if (inc_pulse != dec_pulse) begin
        if (!sel) m_shadow_gain   = clampi(m_shadow_gain + (inc_pulse ? 6 : -6), 0, 255);
        else      m_shadow_bright = clampi(m_shadow_bright + (inc_pulse ? 6 : -6), -128, 127);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge Pclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic keys(input int n, input logic up, input logic s);
    sel = s;
    for (int i = 0; i < n; i++) begin
      inc_pulse = up;
      dec_pulse = !up;
      cyc();
    end
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
  endtask

  task automatic frame_start();
    Vsync = 1'b1;
    cyc();
    Vsync = 1'b0;
    cyc();
  endtask

  task automatic send_pixel(input string name, input logic [W-1:0] px, input int exp);
    RGB = px;
    De  = 1'b1;
    cyc();
    De  = 1'b0;
    cyc();
    cyc();
    check(name, int'(RGB_o), exp);
  endtask

  // ---------------- stimulus + compare ----------------
  initial begin
    Rst = 1'b1; Vsync = 1'b0; Hsync = 1'b0; De = 1'b0; RGB = '0;
    inc_pulse = 1'b0; dec_pulse = 1'b0; sel = 1'b0; bypass = 1'b0;
    fork
      begin : stim
        repeat (3) cyc();
        check("reset_rgb", int'(RGB_o), 0);
        check("reset_de", int'(De_o), 0);
        check("reset_gain", int'(cur_gain), 64);
        check("reset_bright", int'($signed(cur_bright)), 0);
        Rst = 1'b0;
        check_en = 1'b1;

        // neutral settings frame
        frame_start();
        for (int i = 0; i < 100; i++) begin
          Hsync = (i % 20) < 2;
          De    = (i % 20) >= 4;
          RGB   = 24'h804020;
          cyc();
        end
        check("neutral_rgb", int'(RGB_o), 'h804020);
        De = 1'b0; Hsync = 1'b0;
        repeat (3) cyc();

        // contrast step and commit timing
        keys(1, 1'b1, 1'b0);
        check("gain_pre_commit", int'(cur_gain), 64);
        frame_start();
        check("gain_commit", int'(cur_gain), 70);
        send_pixel("gain70_c0", 24'hC0C0C0, 'hC6C6C6);
        Vsync = 1'b1; inc_pulse = 1'b1;
        cyc();
        Vsync = 1'b0; inc_pulse = 1'b0;
        cyc();
        check("edge_pulse_deferred", int'(cur_gain), 70);
        frame_start();
        check("edge_pulse_next_frame", int'(cur_gain), 76);
        inc_pulse = 1'b1; dec_pulse = 1'b1;
        cyc();
        inc_pulse = 1'b0; dec_pulse = 1'b0;
        frame_start();
        check("inc_dec_cancel", int'(cur_gain), 76);
        keys(1, 1'b0, 1'b0);
        frame_start();
        check("gain_back_70", int'(cur_gain), 70);

        // brightness saturation
        keys(30, 1'b1, 1'b1);
        frame_start();
        check("bright_max", int'($signed(cur_bright)), 127);
        send_pixel("bright_hi_clamp", 24'hF0F0F0, 'hFFFFFF);
        keys(60, 1'b0, 1'b1);
        frame_start();
        check("bright_min", int'($signed(cur_bright)), -128);
        send_pixel("bright_lo_clamp", 24'h101010, 0);

        // zero gain: every pixel collapses to mid-grey + brightness
        keys(26, 1'b1, 1'b1);
        keys(12, 1'b0, 1'b0);
        frame_start();
        check("gain_zero", int'(cur_gain), 0);
        check("bright_28", int'($signed(cur_bright)), 28);
        send_pixel("gain0_a", 24'h00FF37, 'h9C9C9C);
        send_pixel("gain0_b", 24'hFF0000, 'h9C9C9C);
        for (int i = 0; i < 16; i++) begin
          RGB = W'($urandom_range(0, 24'hFFFFFF));
          De  = 1'b1;
          cyc();
        end
        De = 1'b0;

        // max gain, bypass, blanking
        keys(43, 1'b1, 1'b0);
        keys(12, 1'b1, 1'b1);
        frame_start();
        check("gain_max", int'(cur_gain), 255);
        check("bright_100", int'($signed(cur_bright)), 100);
        send_pixel("gain255_adj", 24'h7F8081, 'hE0E4E7);
        bypass = 1'b1;
        send_pixel("bypass_exact", 24'h123456, 'h123456);
        RGB = 24'hABCDEF; De = 1'b0;
        repeat (3) cyc();
        check("blank_zero", int'(RGB_o), 0);
        RGB = 24'h7F8081; De = 1'b1; bypass = 1'b0;
        cyc();
        bypass = 1'b1;
        cyc();
        De = 1'b0; bypass = 1'b0;
        cyc();
        check("byp_travel_adj", int'(RGB_o), 'hE0E4E7);
        cyc();
        check("byp_travel_raw", int'(RGB_o), 'h7F8081);
        for (int i = 0; i < 24; i++) begin
          RGB    = W'($urandom_range(0, 24'hFFFFFF));
          De     = ($urandom_range(0, 3) != 0);
          bypass = i[0];
          Hsync  = (i % 8) == 0;
          cyc();
        end
        bypass = 1'b0; Hsync = 1'b0;

        // async reset mid-line
        De = 1'b1; RGB = 24'h804020;
        repeat (5) cyc();
        #2;
        Rst = 1'b1;
        #1;
        check("rst_async_rgb", int'(RGB_o), 0);
        check("rst_async_de", int'(De_o), 0);
        check("rst_gain", int'(cur_gain), 64);
        check("rst_bright", int'($signed(cur_bright)), 0);
        cyc();
        Rst = 1'b0; RGB = 24'h112233; De = 1'b1;
        cyc();
        check("rst_flush_1", int'(De_o), 0);
        cyc();
        check("rst_flush_2", int'(De_o), 0);
        cyc();
        check("rst_resume_de", int'(De_o), 1);
        check("rst_resume_rgb", int'(RGB_o), 'h112233);
        De = 1'b0;
        repeat (4) cyc();
        done = 1'b1;
      end
      begin : cmp
        while (!done) begin
          @(negedge Pclk);
          if (!done && check_en && !Rst) begin
            n_checks++;
            if ({Vsync_o, Hsync_o, De_o, RGB_o} !== exp_q[0] || cur_gain !== 8'(m_gain)
                || int'($signed(cur_bright)) != m_bright) begin
              n_errors++;
              $display("FAIL cycle_cmp t=%0t: got sync/de/rgb=%h gain=%0d bright=%0d, expected %h gain=%0d bright=%0d",
                       $time, {Vsync_o, Hsync_o, De_o, RGB_o}, cur_gain, $signed(cur_bright),
                       exp_q[0], m_gain, m_bright);
            end
          end
        end
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
